// File: rtl/matrix_mac_engine_pkg.sv
// Shared types and helpers for the sequential matrix multiply-accumulate engine.
package matrix_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mme_state_t;

  // Saturation helpers work on a fixed wide value; callers keep the low bits they need.
  localparam int SAT_W = 64;

  function automatic int acc_width(input int elem_w, input int k);
    return 2 * elem_w + $clog2(k) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] value,
                                                          input int rw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (rw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (rw - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_unsigned(input logic signed [SAT_W-1:0] value,
                                                            input int rw);
    logic signed [SAT_W-1:0] hi;
    hi = (64'sd1 <<< rw) - 64'sd1;
    if (value > hi) return hi;
    if (value < 64'sd0) return 64'sd0;
    return value;
  endfunction

endpackage

// File: rtl/matrix_mac_engine_mac_unit.sv
// One multiplier plus accumulator with sign/zero extension and a converter that
// reduces the running sum to the result width, flagging out-of-range values.
module mac_unit
  import matrix_pkg::*;
#(
  parameter int EW       = 14,
  parameter int RW       = 14,
  parameter int ACC_W    = 31,
  parameter int SATURATE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          first_i,
  input  logic          signed_i,
  input  logic [EW-1:0] a_i,
  input  logic [EW-1:0] b_i,
  output logic [RW-1:0] result_o,
  output logic          ovf_o
);

  logic signed [ACC_W-1:0] a_ext, b_ext, prod, acc_q, acc_d;
  logic signed [SAT_W-1:0] wide, clamped;

  always_comb begin
    if (signed_i) begin
      a_ext = {{(ACC_W-EW){a_i[EW-1]}}, a_i};
      b_ext = {{(ACC_W-EW){b_i[EW-1]}}, b_i};
    end else begin
      a_ext = {{(ACC_W-EW){1'b0}}, a_i};
      b_ext = {{(ACC_W-EW){1'b0}}, b_i};
    end
    prod  = a_ext * b_ext;
    acc_d = first_i ? prod : acc_q + prod;
    // acc_d is the element value including this cycle's product, so the converter
    // sees the finished element on the last inner-dimension step.
    wide    = {{(SAT_W-ACC_W){acc_d[ACC_W-1]}}, acc_d};
    clamped = signed_i ? sat_signed(wide, RW) : sat_unsigned(wide, RW);
    ovf_o   = (clamped != wide);
    result_o = (SATURATE != 0) ? clamped[RW-1:0] : wide[RW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

endmodule

// File: rtl/matrix_mac_engine.sv
// Sequential C = A x B: one MAC per cycle, k innermost, then j, then i. Results
// collect in a shadow buffer and are published to C_out together with done.
module matrix_mac_engine
  import matrix_pkg::*;
#(
  parameter int ROWS_A       = 2,
  parameter int COLS_A       = 3,
  parameter int COLS_B       = 2,
  parameter int ELEM_WIDTH   = 14,
  parameter int RESULT_WIDTH = 14,
  parameter int SATURATE     = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     signed_mode,
  input  logic [ROWS_A*COLS_A*ELEM_WIDTH-1:0]      A_in,
  input  logic [COLS_A*COLS_B*ELEM_WIDTH-1:0]      B_in,
  output logic [ROWS_A*COLS_B*RESULT_WIDTH-1:0]    C_out,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     overflow,
  output logic                                     state_dbg_o
);

  localparam int NA    = ROWS_A * COLS_A;
  localparam int NB    = COLS_A * COLS_B;
  localparam int NC    = ROWS_A * COLS_B;
  localparam int RW    = RESULT_WIDTH;
  localparam int ACC_W = acc_width(ELEM_WIDTH, COLS_A);
  localparam int IW    = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
  localparam int JW    = (COLS_B > 1) ? $clog2(COLS_B) : 1;
  localparam int KW    = (COLS_A > 1) ? $clog2(COLS_A) : 1;
  localparam int AW    = (NA > 1) ? $clog2(NA) : 1;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW    = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(ROWS_A - 1);
  localparam logic [JW-1:0] J_LAST = JW'(COLS_B - 1);
  localparam logic [KW-1:0] K_LAST = KW'(COLS_A - 1);

  mme_state_t state_q, state_d;
  logic [IW-1:0]         i_q;
  logic [JW-1:0]         j_q;
  logic [KW-1:0]         k_q;
  logic [ELEM_WIDTH-1:0] a_buf_q [NA];
  logic [ELEM_WIDTH-1:0] b_buf_q [NB];
  logic                  sgn_q;
  logic [RW-1:0]         shadow_q [NC];
  logic [NC*RW-1:0]      c_out_q;
  logic                  done_q, ovf_q;

  logic          accept, k_last, last_mac, mac_en, mac_first, mac_ovf;
  logic [AW-1:0] a_idx;
  logic [BW-1:0] b_idx;
  logic [CW-1:0] c_idx;
  logic [RW-1:0] mac_result;

  always_comb begin
    accept   = start && (state_q == IDLE);
    k_last   = (k_q == K_LAST);
    last_mac = k_last && (j_q == J_LAST) && (i_q == I_LAST);
    a_idx    = AW'(int'(i_q) * COLS_A + int'(k_q));
    b_idx    = BW'(int'(k_q) * COLS_B + int'(j_q));
    c_idx    = CW'(int'(i_q) * COLS_B + int'(j_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_mac) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN);
    mac_en      = (state_q == RUN);
    mac_first   = (k_q == '0);
    state_dbg_o = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      c_out_q <= '0;
      for (int n = 0; n < NA; n++) a_buf_q[n] <= '0;
      for (int n = 0; n < NB; n++) b_buf_q[n] <= '0;
      for (int n = 0; n < NC; n++) shadow_q[n] <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        for (int n = 0; n < NA; n++) a_buf_q[n] <= A_in[n*ELEM_WIDTH +: ELEM_WIDTH];
        for (int n = 0; n < NB; n++) b_buf_q[n] <= B_in[n*ELEM_WIDTH +: ELEM_WIDTH];
        sgn_q <= signed_mode;
        ovf_q <= 1'b0;
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
      end else if (mac_en) begin
        if (k_last) begin
          k_q <= '0;
          shadow_q[c_idx] <= mac_result;
          if (mac_ovf) ovf_q <= 1'b1;
          if (j_q == J_LAST) begin
            j_q <= '0;
            i_q <= (i_q == I_LAST) ? '0 : i_q + IW'(1);
          end else begin
            j_q <= j_q + JW'(1);
          end
        end else begin
          k_q <= k_q + KW'(1);
        end
        // The final element bypasses the shadow buffer so C_out updates on the done edge.
        if (last_mac) begin
          done_q <= 1'b1;
          for (int n = 0; n < NC; n++)
            c_out_q[n*RW +: RW] <= (CW'(n) == c_idx) ? mac_result : shadow_q[n];
        end
      end
    end
  end

  mac_unit #(
    .EW       (ELEM_WIDTH),
    .RW       (RESULT_WIDTH),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en_i     (mac_en),
    .first_i  (mac_first),
    .signed_i (sgn_q),
    .a_i      (a_buf_q[a_idx]),
    .b_i      (b_buf_q[b_idx]),
    .result_o (mac_result),
    .ovf_o    (mac_ovf)
  );

  assign C_out    = c_out_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: a default-size instance driven from a vector table with
// a done-triggered scoreboard, plus two small 8-bit instances for saturate/wrap cases.
module tb_matrix_mac_engine;

  localparam int RA = 2, KA = 3, CB = 2, EW = 14, RW = 14;
  localparam int N  = RA * KA * CB;
  localparam int SN = 8;
  localparam int NV = 10;

  typedef struct packed {
    logic [RA*KA*EW-1:0] a;
    logic [KA*CB*EW-1:0] b;
    logic                sgn;
    logic [RA*CB*RW-1:0] c;
    logic                ovf;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default-size DUT
  logic                start, signed_mode, busy, done, overflow, st_dbg;
  logic [RA*KA*EW-1:0] a_in;
  logic [KA*CB*EW-1:0] b_in;
  logic [RA*CB*RW-1:0] c_out;

  matrix_mac_engine dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A_in(a_in), .B_in(b_in), .C_out(c_out), .busy(busy), .done(done),
    .overflow(overflow), .state_dbg_o(st_dbg)
  );

  // 2x2x2, 8-bit instances: saturating and wrapping
  logic        s_start, s_sgn;
  logic [31:0] s_a, s_b, s_c_sat, s_c_wrap;
  logic        s_busy_sat, s_done_sat, s_ovf_sat, s_st_sat;
  logic        s_busy_wrap, s_done_wrap, s_ovf_wrap, s_st_wrap;

  matrix_mac_engine #(.ROWS_A(2), .COLS_A(2), .COLS_B(2), .ELEM_WIDTH(8),
                      .RESULT_WIDTH(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .signed_mode(s_sgn),
    .A_in(s_a), .B_in(s_b), .C_out(s_c_sat), .busy(s_busy_sat), .done(s_done_sat),
    .overflow(s_ovf_sat), .state_dbg_o(s_st_sat)
  );

  matrix_mac_engine #(.ROWS_A(2), .COLS_A(2), .COLS_B(2), .ELEM_WIDTH(8),
                      .RESULT_WIDTH(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(s_start), .signed_mode(s_sgn),
    .A_in(s_a), .B_in(s_b), .C_out(s_c_wrap), .busy(s_busy_wrap), .done(s_done_wrap),
    .overflow(s_ovf_wrap), .state_dbg_o(s_st_wrap)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6*EW-1:0] pk6(input int e0, e1, e2, e3, e4, e5);
    int e[6];
    logic [6*EW-1:0] r;
    e = '{e0, e1, e2, e3, e4, e5};
    for (int n = 0; n < 6; n++) r[n*EW +: EW] = EW'(e[n]);
    return r;
  endfunction

  function automatic logic [4*RW-1:0] pk4(input int e0, e1, e2, e3);
    int e[4];
    logic [4*RW-1:0] r;
    e = '{e0, e1, e2, e3};
    for (int n = 0; n < 4; n++) r[n*RW +: RW] = RW'(e[n]);
    return r;
  endfunction

  // Reference product with range clamping (default instance saturates).
  function automatic void model(input logic [RA*KA*EW-1:0] a, input logic [KA*CB*EW-1:0] b,
                                input logic sgn, output logic [RA*CB*RW-1:0] c,
                                output logic ov);
    longint s, x, y, hi, lo;
    if (sgn) begin
      hi = longint'((1 << (RW - 1)) - 1);
      lo = -longint'(1 << (RW - 1));
    end else begin
      hi = longint'((1 << RW) - 1);
      lo = 0;
    end
    c  = '0;
    ov = 1'b0;
    for (int i = 0; i < RA; i++)
      for (int j = 0; j < CB; j++) begin
        s = 0;
        for (int k = 0; k < KA; k++) begin
          if (sgn) begin
            x = longint'($signed(a[(i*KA+k)*EW +: EW]));
            y = longint'($signed(b[(k*CB+j)*EW +: EW]));
          end else begin
            x = longint'(a[(i*KA+k)*EW +: EW]);
            y = longint'(b[(k*CB+j)*EW +: EW]);
          end
          s += x * y;
        end
        if (s > hi) begin s = hi; ov = 1'b1; end
        else if (s < lo) begin s = lo; ov = 1'b1; end
        c[(i*CB+j)*RW +: RW] = RW'(s);
      end
  endfunction

  // scoreboard
  logic [RA*CB*RW-1:0] exp_q[$];
  logic                exp_ovf_q[$];
  int                  exp_cyc_q[$];

  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("c_out", c_out, exp_q.pop_front());
        check("overflow", overflow, exp_ovf_q.pop_front());
        check("done_latency", cyc, exp_cyc_q.pop_front());
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  // driver: call at a negedge with the DUT idle (or in its done cycle)
  task automatic drive(input vec_t v);
    a_in = v.a;
    b_in = v.b;
    signed_mode = v.sgn;
    start = 1'b1;
    exp_q.push_back(v.c);
    exp_ovf_q.push_back(v.ovf);
    exp_cyc_q.push_back(cyc + N + 1);
  endtask

  task automatic run_op(input vec_t v, input int hold, input bit scramble);
    logic [RA*CB*RW-1:0] c_before;
    bit stable;
    int t;
    c_before = c_out;
    drive(v);
    @(negedge clk);
    t = 1;
    start = (hold > 0);
    check("busy_after_accept", busy, 1'b1);
    check("state_run", st_dbg, 1'b1);
    stable = 1'b1;
    while (!done && t < N + 4) begin
      if (scramble) begin
        for (int n = 0; n < RA*KA; n++) a_in[n*EW +: EW] = EW'($urandom());
        for (int n = 0; n < KA*CB; n++) b_in[n*EW +: EW] = EW'($urandom());
        signed_mode = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      t++;
      start = (t <= hold);
      if (!done && (c_out !== c_before || busy !== 1'b1)) stable = 1'b0;
    end
    start = 1'b0;
    check("c_stable_while_busy", stable, 1'b1);
    check("done_in_time", done, 1'b1);
  endtask

  task automatic run_small(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_sat, input logic [31:0] exp_wrap,
                           input logic ov_sat, input logic ov_wrap);
    int t0, t;
    t0 = cyc;
    s_a = a;
    s_b = b;
    s_sgn = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    t = 1;
    while (!s_done_sat && t < SN + 4) begin
      @(negedge clk);
      t++;
    end
    check("s_done_seen", s_done_sat, 1'b1);
    check("s_latency", cyc - t0, SN + 1);
    check("s_c_sat", s_c_sat, exp_sat);
    check("s_ovf_sat", s_ovf_sat, ov_sat);
    check("s_done_wrap", s_done_wrap, 1'b1);
    check("s_c_wrap", s_c_wrap, exp_wrap);
    check("s_ovf_wrap", s_ovf_wrap, ov_wrap);
    check("s_idle_at_done", {s_st_sat, s_busy_sat, s_st_wrap, s_busy_wrap}, 4'b0000);
    @(negedge clk);
    check("s_done_pulse", {s_done_sat, s_done_wrap}, 2'b00);
    check("s_c_held", s_c_sat, exp_sat);
  endtask

  vec_t vecs[NV];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    a_in = '0;
    b_in = '0;
    s_start = 1'b0;
    s_sgn = 1'b0;
    s_a = '0;
    s_b = '0;

    vecs[0] = '{a: pk6(1, -2, 3, -1, 0, 2), b: pk6(2, 1, -1, 0, 4, -3), sgn: 1'b1,
                c: pk4(16, -8, 6, -7), ovf: 1'b0};
    vecs[1] = '{a: pk6(1, 2, 3, 4, 5, 6), b: pk6(7, 8, 9, 10, 11, 12), sgn: 1'b0,
                c: pk4(58, 64, 139, 154), ovf: 1'b0};
    vecs[2] = '{a: pk6(8191, 8191, 8191, 8191, 8191, 8191),
                b: pk6(8191, 8191, 8191, 8191, 8191, 8191), sgn: 1'b1,
                c: pk4(8191, 8191, 8191, 8191), ovf: 1'b1};
    vecs[3] = '{a: pk6(-8192, -8192, -8192, -8192, -8192, -8192),
                b: pk6(8191, 8191, 8191, 8191, 8191, 8191), sgn: 1'b1,
                c: pk4(-8192, -8192, -8192, -8192), ovf: 1'b1};
    vecs[4] = '{a: pk6(16383, 16383, 16383, 16383, 16383, 16383),
                b: pk6(1, 1, 1, 1, 1, 1), sgn: 1'b0,
                c: pk4(16383, 16383, 16383, 16383), ovf: 1'b1};
    vecs[5] = '{a: pk6(-1, -1, -1, -1, -1, -1), b: pk6(-1, -1, -1, -1, -1, -1), sgn: 1'b1,
                c: pk4(3, 3, 3, 3), ovf: 1'b0};
    vecs[6] = '{a: '0, b: '0, sgn: 1'b1, c: '0, ovf: 1'b0};
    for (int r = 7; r < NV; r++) begin
      vecs[r].sgn = (r != 7);
      for (int n = 0; n < 6; n++) begin
        if (vecs[r].sgn) begin
          vecs[r].a[n*EW +: EW] = EW'(int'($urandom_range(0, 200)) - 100);
          vecs[r].b[n*EW +: EW] = EW'(int'($urandom_range(0, 200)) - 100);
        end else begin
          vecs[r].a[n*EW +: EW] = EW'($urandom_range(0, 63));
          vecs[r].b[n*EW +: EW] = EW'($urandom_range(0, 63));
        end
      end
      model(vecs[r].a, vecs[r].b, vecs[r].sgn, vecs[r].c, vecs[r].ovf);
    end

    @(negedge clk);
    check("rst_c_out", c_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", st_dbg, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // table: every op starts in the previous op's done cycle (back-to-back)
    for (int r = 0; r < NV; r++)
      run_op(vecs[r], (r == 1) ? 5 : 0, (r == 0 || r >= 7));

    // reset in the middle of an op that has already raised overflow
    drive(vecs[2]);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_c_out", c_out, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_state", st_dbg, 1'b0);
    exp_q.delete();
    exp_ovf_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(vecs[0], 0, 1'b0);

    // 2x2x2, 8-bit: identity product, then all-200 overflow (sat 255 / wrap 8'h80)
    @(negedge clk);
    run_small(32'h04030201, 32'h01000001, 32'h04030201, 32'h04030201, 1'b0, 1'b0);
    run_small(32'hC8C8C8C8, 32'hC8C8C8C8, 32'hFFFFFFFF, 32'h80808080, 1'b1, 1'b1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
